// File: rtl/corr_pkg.sv
// Shared geometry, widths and FSM state type for the XOR motion correlator.
package corr_pkg;

  localparam int ROW_BITS    = 128;
  localparam int FRAME_ROWS  = 256;
  localparam int ROW_FIRST   = 16;
  localparam int ROW_LAST    = 239;
  localparam int COL_LO      = 16;
  localparam int COL_HI      = 111;
  localparam int OFFSET_BIAS = 16;
  localparam int OFFSET_MAX  = 32;

  localparam int WIN_BITS = COL_HI - COL_LO + 1;  // 96 compared columns per row
  localparam int ADDR_W   = 9;                    // two frames of FRAME_ROWS words
  localparam int CNT_W    = 7;                    // 0..96 fits in 7 bits
  localparam int SUM_W    = 16;                   // 224*96 = 21504 fits in 16 bits

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } corr_state_t;

endpackage

// File: rtl/xor_correlator_popcount96.sv
// Combinational population count of the 96-bit per-row mismatch vector.
module popcount96
  import corr_pkg::*;
(
  input  logic [WIN_BITS-1:0] vec,
  output logic [CNT_W-1:0]    count
);

  // Sum every set bit; synthesis folds the loop into an adder tree.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIN_BITS; i++) begin
      count = count + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/xor_correlator.sv
// XOR mismatch count between the current frame and a displaced reference
// frame, both read row by row from a shared 1-cycle-latency BRAM.
module xor_correlator
  import corr_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 go,
  input  logic [ROW_BITS-1:0]  bram_data,
  output logic [ADDR_W-1:0]    bram_addr,
  input  logic [5:0]           x_offset,
  input  logic [5:0]           y_offset,
  input  logic                 curr_frame_bram_offset_sel,
  output logic [SUM_W-1:0]     corr_sum,
  output logic                 done
);

  // Clamp a biased offset to OFFSET_MAX so the displacement stays in [-16,+16].
  function automatic logic [5:0] sat_offset(input logic [5:0] o);
    return (o > 6'(OFFSET_MAX)) ? 6'(OFFSET_MAX) : o;
  endfunction

  // Reference columns [111+dx:16+dx] equal the word shifted right by 16+dx,
  // which is exactly the saturated biased x offset.
  function automatic logic [WIN_BITS-1:0] ref_window(input logic [ROW_BITS-1:0] w,
                                                     input logic [5:0]          shift);
    return WIN_BITS'(w >> shift);
  endfunction

  // Displaced reference row; row range and dy limits keep it inside the frame.
  function automatic logic [7:0] ref_row(input logic [7:0]        r,
                                         input logic signed [6:0] dy);
    return r + {dy[6], dy};
  endfunction

  corr_state_t state, state_nxt;

  logic                start;
  logic                last_issue;
  logic [7:0]          row;
  logic                phase_ref;
  logic                iss_cur, iss_ref;

  logic                sel_q;
  logic [5:0]          xs_q;
  logic signed [6:0]   dy_q;

  logic                vld_cur_p0, vld_ref_p0, vld_p1;
  logic [WIN_BITS-1:0] cur_p0;
  logic [WIN_BITS-1:0] diff_p0;
  logic [CNT_W-1:0]    cnt_p0, cnt_p1;

  assign start      = (state == ST_IDLE) && go;
  assign last_issue = (state == ST_RUN) && phase_ref && (row == 8'(ROW_LAST));
  assign done       = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode; DONE waits for go to drop so a held request runs once.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (go) state_nxt = ST_RUN;
      ST_RUN:   if (last_issue) state_nxt = ST_DRAIN;
      ST_DRAIN: if (vld_p1 && !vld_ref_p0) state_nxt = ST_DONE;
      ST_DONE:  if (!go) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Capture displacement and frame select at start; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (start) begin
      sel_q <= curr_frame_bram_offset_sel;
      xs_q  <= sat_offset(x_offset);
      dy_q  <= $signed({1'b0, sat_offset(y_offset)}) - 7'sd16;
    end
  end

  // Address sequencer: current row, then its displaced reference row, per row.
  // The first address uses the live select since the latched copy lands on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bram_addr <= '0;
      row       <= '0;
      phase_ref <= 1'b0;
      iss_cur   <= 1'b0;
      iss_ref   <= 1'b0;
    end else if (start) begin
      bram_addr <= {curr_frame_bram_offset_sel, 8'(ROW_FIRST)};
      row       <= 8'(ROW_FIRST);
      phase_ref <= 1'b0;
      iss_cur   <= 1'b1;
      iss_ref   <= 1'b0;
    end else if (state == ST_RUN) begin
      if (!phase_ref) begin
        bram_addr <= {~sel_q, ref_row(row, dy_q)};
        phase_ref <= 1'b1;
        iss_cur   <= 1'b0;
        iss_ref   <= 1'b1;
      end else if (row == 8'(ROW_LAST)) begin
        iss_cur   <= 1'b0;
        iss_ref   <= 1'b0;
      end else begin
        bram_addr <= {sel_q, row + 8'd1};
        row       <= row + 8'd1;
        phase_ref <= 1'b0;
        iss_cur   <= 1'b1;
        iss_ref   <= 1'b0;
      end
    end else begin
      iss_cur <= 1'b0;
      iss_ref <= 1'b0;
    end
  end

  // ---- Stage p0: BRAM word present; tag it as current or reference ----
  // Valid tags follow the issued address by the BRAM read latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_cur_p0 <= 1'b0;
      vld_ref_p0 <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      vld_cur_p0 <= iss_cur;
      vld_ref_p0 <= iss_ref;
      vld_p1     <= vld_ref_p0;
    end
  end

  assign diff_p0 = cur_p0 ^ ref_window(bram_data, xs_q);

  popcount96 u_popcount (
    .vec   (diff_p0),
    .count (cnt_p0)
  );

  // ---- Stage p1: hold current window, register per-row mismatch count ----
  // Data registers carry no reset; the valid tags qualify them.
  always_ff @(posedge clk) begin
    if (vld_cur_p0) cur_p0 <= bram_data[COL_HI:COL_LO];
    if (vld_ref_p0) cnt_p1 <= cnt_p0;
  end

  // ---- Stage p2: accumulate; cleared on start, held afterwards ----
  // Accumulate into the output register; it retains the result until the next start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     corr_sum <= '0;
    else if (start)  corr_sum <= '0;
    else if (vld_p1) corr_sum <= corr_sum + SUM_W'(cnt_p1);
  end

endmodule

// File: tb/tb_xor_correlator.sv
// Scoreboard bench for xor_correlator: randomized frames and offsets, a
// bit-level reference model, and a monitor that checks each completed result.
module tb_xor_correlator;

  logic         clk = 1'b0;
  logic         resetn;
  logic         go;
  logic [127:0] bram_data;
  logic [8:0]   bram_addr;
  logic [5:0]   x_offset;
  logic [5:0]   y_offset;
  logic         sel;
  logic [15:0]  corr_sum;
  logic         done;

  logic [127:0] mem [0:511];

  typedef struct {
    logic [15:0] sum;
    int          e0;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  xor_correlator dut (
    .clk                        (clk),
    .resetn                     (resetn),
    .go                         (go),
    .bram_data                  (bram_data),
    .bram_addr                  (bram_addr),
    .x_offset                   (x_offset),
    .y_offset                   (y_offset),
    .curr_frame_bram_offset_sel (sel),
    .corr_sum                   (corr_sum),
    .done                       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    bram_data <= mem[bram_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: count differing pixels over the window, straight from frame geometry.
  function automatic int model(input int x, input int y, input bit s);
    int xs, ys, dx, dy, cb, rb, n;
    logic [127:0] cw, rw;
    xs = (x > 32) ? 32 : x;
    ys = (y > 32) ? 32 : y;
    dx = xs - 16;
    dy = ys - 16;
    cb = s ? 256 : 0;
    rb = s ? 0 : 256;
    n  = 0;
    for (int r = 16; r <= 239; r++) begin
      cw = mem[cb + r];
      rw = mem[rb + r + dy];
      for (int c = 16; c <= 111; c++) begin
        if (cw[c] != rw[c + dx]) n++;
      end
    end
    return n;
  endfunction

  // Monitor: every rising done must match the oldest outstanding expectation.
  initial begin : monitor
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("corr_sum", int'(corr_sum), int'(e.sum));
          check("done_latency", cyc - e.e0, 450);
        end
      end
      done_q = done;
    end
  end

  task automatic do_run(input string nm, input int x, input int y, input bit s,
                        input int exp, input int hold, input bit chk_addr,
                        input int a0, input int a1, input int a2, input int a3);
    int w;
    int addrs [4];
    @(negedge clk);
    x_offset = 6'(x);
    y_offset = 6'(y);
    sel      = s;
    go       = 1'b1;
    sb_q.push_back('{sum: 16'(exp), e0: cyc + 1});
    w = 0;
    while (!done && w < 1000) begin
      @(negedge clk);
      w++;
      if (w <= 4) addrs[w-1] = int'(bram_addr);
      if (w == 1) begin
        x_offset = 6'($urandom());
        y_offset = 6'($urandom());
        sel      = 1'($urandom());
      end
    end
    check({nm, "_done_seen"}, int'(done), 1);
    if (chk_addr) begin
      check({nm, "_addr1"}, addrs[0], a0);
      check({nm, "_addr2"}, addrs[1], a1);
      check({nm, "_addr3"}, addrs[2], a2);
      check({nm, "_addr4"}, addrs[3], a3);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({nm, "_done_held"}, int'(done), 1);
    end
    go = 1'b0;
    @(negedge clk);
    check({nm, "_done_fall"}, int'(done), 0);
    check({nm, "_sum_retained"}, int'(corr_sum), exp);
  endtask

  initial begin : stimulus
    int e;
    resetn   = 1'b0;
    go       = 1'b0;
    x_offset = 6'd16;
    y_offset = 6'd16;
    sel      = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    check("reset_addr", int'(bram_addr), 0);
    check("reset_sum", int'(corr_sum), 0);
    check("reset_done", int'(done), 0);
    resetn = 1'b1;

    // All-zero frames
    do_run("zero", 16, 16, 1'b0, 0, 0, 1'b1, 16, 272, 17, 273);

    // Current zeros, reference ones
    for (int i = 256; i < 512; i++) mem[i] = '1;
    do_run("ones", 16, 16, 1'b0, 16'h5400, 0, 1'b0, 0, 0, 0, 0);
    do_run("swap", 16, 16, 1'b1, 16'h5400, 0, 1'b1, 272, 16, 273, 17);

    // Reference is the current frame displaced by dx=-4, dy=-1
    for (int r = 0; r < 256; r++) mem[r] = rand128();
    for (int s = 0; s < 255; s++) mem[256 + s] = mem[s + 1] >> 4;
    mem[511] = rand128();
    do_run("shift_match", 12, 15, 1'b0, 0, 0, 1'b1, 16, 271, 17, 272);
    e = model(16, 16, 1'b0);
    check("shift_nomatch_nonzero", int'(e != 0), 1);
    do_run("shift_nomatch", 16, 16, 1'b0, e, 0, 1'b0, 0, 0, 0, 0);

    // Random frames, random and saturating offsets
    for (int i = 0; i < 512; i++) mem[i] = rand128();
    do_run("rand_sat_a", 45, 0, 1'b0, model(45, 0, 1'b0), 0, 1'b0, 0, 0, 0, 0);
    do_run("rand_sat_b", 63, 50, 1'b1, model(63, 50, 1'b1), 0, 1'b0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      int rx, ry;
      bit rs;
      rx = int'($urandom_range(0, 32));
      ry = int'($urandom_range(0, 32));
      rs = 1'($urandom());
      do_run("rand", rx, ry, rs, model(rx, ry, rs), 0, 1'b0, 0, 0, 0, 0);
    end

    // Handshake: held go gives one run, rerun gives the same answer
    e = model(20, 9, 1'b1);
    do_run("hold", 20, 9, 1'b1, e, 20, 1'b0, 0, 0, 0, 0);
    do_run("rerun", 20, 9, 1'b1, e, 0, 1'b0, 0, 0, 0, 0);

    // Reset in the middle of a run
    @(negedge clk);
    x_offset = 6'd16;
    y_offset = 6'd16;
    sel      = 1'b0;
    go       = 1'b1;
    repeat (200) @(negedge clk);
    resetn = 1'b0;
    go     = 1'b0;
    #1;
    check("midreset_done", int'(done), 0);
    check("midreset_sum", int'(corr_sum), 0);
    check("midreset_addr", int'(bram_addr), 0);
    @(negedge clk);
    resetn = 1'b1;
    do_run("after_reset", 30, 3, 1'b0, model(30, 3, 1'b0), 0, 1'b0, 0, 0, 0, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
